// File: rtl/hdsiso8_arb_seq_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// hdsiso8_arb_seq_if: requester + SISO datapath bundle for hdsiso8_arb_seq.
// Rev 1.0
// ----------------------------------------------------------------------------
interface hdsiso8_arb_seq_if #(
  parameter int LEN_W = 4
);
  logic             req_a;
  logic             req_b;
  logic [LEN_W-1:0] len_a;
  logic [LEN_W-1:0] len_b;
  logic             sin_a;
  logic             sin_b;
  logic             siso_out;
  logic             mux_sel;
  logic             siso_din;
  logic             shift_en;
  logic             gnt_a;
  logic             gnt_b;
  logic             busy;
  logic             done;
  logic             dout;
  logic             dout_valid;

  modport master (
    output req_a, req_b, len_a, len_b, sin_a, sin_b, siso_out,
    input  mux_sel, siso_din, shift_en, gnt_a, gnt_b, busy, done, dout, dout_valid
  );

  modport slave (
    input  req_a, req_b, len_a, len_b, sin_a, sin_b, siso_out,
    output mux_sel, siso_din, shift_en, gnt_a, gnt_b, busy, done, dout, dout_valid
  );
endinterface
`default_nettype wire

// File: rtl/hdsiso8_arb_seq.sv
`default_nettype none
// ----------------------------------------------------------------------------
// hdsiso8_arb_seq: round-robin arbiter/sequencer feeding the HDSISO8 shift
// register; optional tail flush via macro HDSEQ_FLUSH_EN.  Rev 1.0
// ----------------------------------------------------------------------------
module hdsiso8_arb_seq #(
  parameter int DEPTH = 8,
  parameter int LEN_W = 4
) (
  input wire               clk,
  input wire               rst,
  hdsiso8_arb_seq_if.slave bus
);

`ifdef HDSEQ_FLUSH_EN
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2,
    S_FLUSH = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;
`endif

  state_t           state_q, state_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic             gnt_a_q, gnt_a_d;
  logic             gnt_b_q, gnt_b_d;
  logic             mux_sel_q, mux_sel_d;
  logic             last_b_q, last_b_d;
  logic [DEPTH-1:0] vld_q, vld_d;

  logic             w_pick_b;
  logic             w_req_own;
  logic             w_fill;
  logic             w_shift;
  state_t           w_after;

  // B wins only if A is absent or A was served last.
  assign w_pick_b  = bus.req_b & (~bus.req_a | ~last_b_q);
  assign w_req_own = (gnt_a_q & bus.req_a) | (gnt_b_q & bus.req_b);

`ifdef HDSEQ_FLUSH_EN
  assign w_fill  = (state_q == S_FLUSH);
  assign w_after = (vld_d != '0) ? S_FLUSH : S_DONE;
`else
  assign w_fill  = 1'b0;
  assign w_after = S_DONE;
`endif

  // A dropped request suppresses the shift in the same cycle (abort).
  assign w_shift = ((state_q == S_SHIFT) & w_req_own) | w_fill;
  assign vld_d   = w_shift ? {vld_q[DEPTH-2:0], ~w_fill} : vld_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    gnt_a_d   = gnt_a_q;
    gnt_b_d   = gnt_b_q;
    mux_sel_d = mux_sel_q;
    last_b_d  = last_b_q;
    case (state_q)
      S_IDLE: begin
        if (bus.req_a | bus.req_b) begin
          gnt_a_d   = ~w_pick_b;
          gnt_b_d   = w_pick_b;
          mux_sel_d = w_pick_b;
          cnt_d     = w_pick_b ? bus.len_b : bus.len_a;
          state_d   = (cnt_d == '0) ? S_DONE : S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (!w_req_own) begin
          state_d = w_after;
        end else begin
          cnt_d = cnt_q - LEN_W'(1);
          if (cnt_q == LEN_W'(1)) begin
            state_d = w_after;
          end
        end
      end
`ifdef HDSEQ_FLUSH_EN
      S_FLUSH: begin
        if (vld_d == '0) begin
          state_d = S_DONE;
        end
      end
`endif
      S_DONE: begin
        state_d  = S_IDLE;
        gnt_a_d  = 1'b0;
        gnt_b_d  = 1'b0;
        last_b_d = gnt_b_q;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      gnt_a_q   <= 1'b0;
      gnt_b_q   <= 1'b0;
      mux_sel_q <= 1'b0;
      last_b_q  <= 1'b1;
      vld_q     <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      gnt_a_q   <= gnt_a_d;
      gnt_b_q   <= gnt_b_d;
      mux_sel_q <= mux_sel_d;
      last_b_q  <= last_b_d;
      vld_q     <= vld_d;
    end
  end

  assign bus.mux_sel    = mux_sel_q;
  assign bus.siso_din   = w_fill ? 1'b0 : (mux_sel_q ? bus.sin_b : bus.sin_a);
  assign bus.shift_en   = w_shift;
  assign bus.gnt_a      = gnt_a_q;
  assign bus.gnt_b      = gnt_b_q;
  assign bus.busy       = (state_q != S_IDLE);
  assign bus.done       = (state_q == S_DONE);
  assign bus.dout       = bus.siso_out;
  assign bus.dout_valid = w_shift & vld_q[DEPTH-1];

endmodule
`default_nettype wire

// File: tb/tb_hdsiso8_arb_seq.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_hdsiso8_arb_seq: scoreboard bench for hdsiso8_arb_seq with a SISO model.
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_hdsiso8_arb_seq;
  localparam int DEPTH = 8;
  localparam int LEN_W = 4;
`ifdef HDSEQ_FLUSH_EN
  localparam int FL = -1;
`else
  localparam int FL = 0;
`endif

  typedef struct {
    logic        owner;
    int          shifts;
    int          flush;
    logic [15:0] bits;
  } xfer_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  hdsiso8_arb_seq_if #(.LEN_W(LEN_W)) bus ();
  hdsiso8_arb_seq #(.DEPTH(DEPTH), .LEN_W(LEN_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // SISO datapath and requester bit streams
  logic [DEPTH-1:0] siso_q = '0;
  logic [15:0]      pat_a = '0, pat_b = '0;
  logic [3:0]       idx_a = '0, idx_b = '0;
  always @(posedge clk) begin
    if (bus.shift_en) siso_q <= {siso_q[DEPTH-2:0], bus.siso_din};
    if (!bus.gnt_a) idx_a <= '0;
    else if (bus.shift_en && !bus.mux_sel) idx_a <= idx_a + 4'd1;
    if (!bus.gnt_b) idx_b <= '0;
    else if (bus.shift_en && bus.mux_sel) idx_b <= idx_b + 4'd1;
  end
  assign bus.siso_out = siso_q[DEPTH-1];
  assign bus.sin_a    = pat_a[idx_a];
  assign bus.sin_b    = pat_b[idx_b];

  // Scoreboard
  xfer_t            gq[$];
  xfer_t            mx;
  logic [DEPTH-1:0] mv = '0, mb = '0;
  int               real_cnt = 0, flush_cnt = 0, cyc = 0, done_cyc = 0;
  logic             pend = 1'b0, prev_g = 1'b0, g, eb;
  logic             tb_last_b = 1'b1;

  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      gq.delete();
      mv = '0; mb = '0;
      real_cnt = 0; flush_cnt = 0;
      pend = 1'b0; prev_g = 1'b0;
    end else begin
      g = bus.gnt_a | bus.gnt_b;
      if (g && !prev_g && pend) begin
        chk("regrant_gap", cyc - done_cyc, 2);
        pend = 1'b0;
      end
      prev_g = g;
      if (bus.shift_en) begin
        chk("dout_valid", bus.dout_valid, mv[DEPTH-1]);
        if (mv[DEPTH-1]) chk("dout", bus.dout, mb[DEPTH-1]);
        if (gq.size() == 0) begin
          chk("shift_no_xfer", bus.shift_en, 0);
        end else if (real_cnt < gq[0].shifts) begin
          eb = gq[0].bits[real_cnt];
          chk("siso_din", bus.siso_din, eb);
          mv = {mv[DEPTH-2:0], 1'b1};
          mb = {mb[DEPTH-2:0], eb};
          real_cnt++;
        end else begin
          chk("filler_din", bus.siso_din, 0);
          mv = {mv[DEPTH-2:0], 1'b0};
          mb = {mb[DEPTH-2:0], 1'b0};
          flush_cnt++;
        end
      end else begin
        chk("dout_valid_noshift", bus.dout_valid, 0);
      end
      if (bus.done) begin
        if (gq.size() == 0) begin
          chk("spurious_done", bus.done, 0);
        end else begin
          mx = gq.pop_front();
          chk("done_gnt_a", bus.gnt_a, !mx.owner);
          chk("done_gnt_b", bus.gnt_b, mx.owner);
          chk("mux_sel", bus.mux_sel, mx.owner);
          chk("n_shifts", real_cnt, mx.shifts);
          if (mx.flush >= 0) chk("n_flush", flush_cnt, mx.flush);
`ifdef HDSEQ_FLUSH_EN
          chk("flushed_empty", mv == '0, 1);
`endif
        end
        real_cnt  = 0;
        flush_cnt = 0;
        pend      = bus.req_a | bus.req_b;
        done_cyc  = cyc;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_checks(input string tag);
    chk({tag, "_gnt_a"}, bus.gnt_a, 0);
    chk({tag, "_gnt_b"}, bus.gnt_b, 0);
    chk({tag, "_mux_sel"}, bus.mux_sel, 0);
    chk({tag, "_shift_en"}, bus.shift_en, 0);
    chk({tag, "_busy"}, bus.busy, 0);
    chk({tag, "_done"}, bus.done, 0);
    chk({tag, "_dout_valid"}, bus.dout_valid, 0);
  endtask

  task automatic do_reset();
    bus.req_a = 1'b0; bus.req_b = 1'b0;
    bus.len_a = '0;   bus.len_b = '0;
    rst = 1'b1;
    #1;
    idle_checks("reset");
    repeat (2) tick();
    rst = 1'b0;
    tb_last_b = 1'b1;
    tick();
  endtask

  // Queue the predicted grant order, then act as both requesters until all are served.
  task automatic serve(input int na, input int nb, input int la, input int lb,
                       input int abort_a, input int fl);
    int    ra, rb, sa, budget;
    logic  pick_b, first_b;
    xfer_t x;
    ra = na; rb = nb;
    first_b = 1'b0;
    while (ra > 0 || rb > 0) begin
      pick_b   = (rb > 0) && (ra == 0 || !tb_last_b);
      if (ra + rb == na + nb) first_b = pick_b;
      x.owner  = pick_b;
      x.shifts = pick_b ? lb : la;
      if (!pick_b && abort_a > 0 && abort_a < la) x.shifts = abort_a;
      x.flush  = fl;
      x.bits   = pick_b ? pat_b : pat_a;
      gq.push_back(x);
      tb_last_b = pick_b;
      if (pick_b) rb--; else ra--;
    end
    bus.len_a = LEN_W'(la);
    bus.len_b = LEN_W'(lb);
    bus.req_a = (na > 0);
    bus.req_b = (nb > 0);
    ra = na; rb = nb; sa = 0; budget = 0;
    while ((ra > 0 || rb > 0) && budget < 300) begin
      tick();
      budget++;
      if (budget == 1) chk("gnt_1cyc", {bus.gnt_b, bus.gnt_a}, first_b ? 2'b10 : 2'b01);
      if (bus.req_a && abort_a > 0 && sa == abort_a) bus.req_a = 1'b0;
      else if (bus.shift_en && bus.gnt_a) sa++;
      if (bus.done) begin
        if (bus.gnt_a) begin ra--; if (ra == 0) bus.req_a = 1'b0; end
        if (bus.gnt_b) begin rb--; if (rb == 0) bus.req_b = 1'b0; end
      end
    end
    chk("timeout", budget < 300, 1);
    tick();
    chk("busy_after", bus.busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    do_reset();

    pat_a = 16'h000D;                 // 1,0,1,1,0
    serve(1, 0, 5, 0, 0, FL);

    do_reset();
    pat_a = 16'h0005; pat_b = 16'h0006;
    serve(1, 1, 3, 3, 0, FL);         // A first after reset, then B

    pat_a = 16'h00B3; pat_b = 16'h0002;
    serve(2, 1, 4, 2, 0, FL);         // A, B, A

    pat_b = 16'hFFFF;
    serve(0, 1, 0, 0, 0, FL);         // zero-length grant

    pat_a = 16'h02A7;
    serve(1, 0, 10, 0, 4, FL);        // abort after 4 shifts

    for (int i = 0; i < 4; i++) begin
      pat_a = 16'($urandom);
      pat_b = 16'($urandom);
      serve(1 + int'($urandom_range(0, 1)), 1 + int'($urandom_range(0, 1)),
            int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), 0, FL);
    end

    // Asynchronous reset in the middle of a transfer
    pat_a = 16'h00FF;
    x_mid: begin
      xfer_t x;
      x.owner = 1'b0; x.shifts = 10; x.flush = FL; x.bits = pat_a;
      gq.push_back(x);
    end
    bus.len_a = 4'd10;
    bus.req_a = 1'b1;
    repeat (3) tick();
    chk("mid_shift_en", bus.shift_en, 1);
    #2 rst = 1'b1;
    #1;
    idle_checks("async_rst");
    bus.req_a = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
    tb_last_b = 1'b1;
    tick();
    pat_a = 16'h0003; pat_b = 16'h0001;
    serve(1, 1, 2, 2, 0, FL);         // A must win the tie again

`ifdef HDSEQ_FLUSH_EN
    do_reset();
    pat_a = 16'h0005;
    serve(1, 0, 3, 0, 0, DEPTH);      // 3 SHIFT + 8 FLUSH cycles
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
